// File: rtl/mips_mem_pkg.sv
// Shared encodings and helpers for the MIPS32 load/store memory access path.
package mips_mem_pkg;

    localparam int LANE_W = 2;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    function automatic logic misaligned(
        input logic [1:0]        size,
        input logic [LANE_W-1:0] offset
    );
        logic bad;
        bad = 1'b0;
        unique case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = offset[0];
            SIZE_W:  bad = |offset;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane steering: sub-word store merge and load extract.
module lsu_byte_lane
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rd_word,
    input  logic [1:0]            size,
    input  logic [LANE_W-1:0]     offset,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] merged,
    output logic [DATA_WIDTH-1:0] extracted
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    logic [SH_W-1:0]       shamt;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] ins;
    logic [DATA_WIDTH-1:0] shifted;

    // Halfwords snap to lane pair 0/1 or 2/3, so only offset[1] matters.
    always_comb begin
        shamt = '0;
        mask  = '0;
        ins   = '0;
        unique case (size)
            SIZE_B: begin
                shamt = SH_W'({offset, 3'b000});
                mask  = DATA_WIDTH'(8'hFF) << shamt;
                ins   = DATA_WIDTH'(wdata[7:0]) << shamt;
            end
            SIZE_H: begin
                shamt = SH_W'({offset[1], 4'b0000});
                mask  = DATA_WIDTH'(16'hFFFF) << shamt;
                ins   = DATA_WIDTH'(wdata[15:0]) << shamt;
            end
            default: begin
                shamt = '0;
                mask  = '1;
                ins   = wdata;
            end
        endcase
    end

    assign merged  = (old_word & ~mask) | (ins & mask);
    assign shifted = rd_word >> shamt;

    always_comb begin
        extracted = shifted;
        unique case (size)
            SIZE_B: begin
                if (is_unsigned)
                    extracted = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
                else
                    extracted = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                if (is_unsigned)
                    extracted = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
                else
                    extracted = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            end
            default: extracted = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the execute stage and word-organised data memory.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_SIZE  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_SIZE-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_misaligned,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_SIZE-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    state_t                state;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [LANE_W-1:0]     off_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] extracted;
    logic                  bad;

    lsu_byte_lane #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
        .old_word    (mem_rd_data),
        .wdata       (wdata_q),
        .rd_word     (mem_rd_data),
        .size        (size_q),
        .offset      (off_q),
        .is_unsigned (uns_q),
        .merged      (merged),
        .extracted   (extracted)
    );

    assign bad = misaligned(req_size, req_addr[LANE_W-1:0]);

    // Strobes decode straight from state so reset kills them at once.
    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign mem_read   = (state == ST_READ);
    assign mem_write  = (state == ST_WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            we_q            <= 1'b0;
            size_q          <= SIZE_B;
            uns_q           <= 1'b0;
            off_q           <= '0;
            wdata_q         <= '0;
            mem_addr        <= '0;
            mem_wr_data     <= '0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        size_q   <= req_size;
                        uns_q    <= req_unsigned;
                        off_q    <= req_addr[LANE_W-1:0];
                        wdata_q  <= req_wdata;
                        mem_addr <= {2'b00, req_addr[ADDR_SIZE-1:2]};
                        if (bad) begin
                            resp_misaligned <= 1'b1;
                            resp_rdata      <= '0;
                            state           <= ST_RESP;
                        end else if (req_we && req_size == SIZE_W) begin
                            mem_wr_data <= req_wdata;
                            state       <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (we_q) begin
                        mem_wr_data <= merged;
                        state       <= ST_WRITE;
                    end else begin
                        resp_rdata <= extracted;
                        state      <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    resp_rdata <= '0;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_rdata      <= '0;
                    resp_misaligned <= 1'b0;
                    state           <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator sitting between the MIPS32 execute stage and the word-organised data memory. Accepts one byte-addressed load or store per request (byte, halfword, word, signed or unsigned), converts it to word-indexed accesses on the memory's MemRead/MemWrite/addr/wr_data/rd_data interface, and performs read-modify-write for sub-word stores. Returns aligned, extended load data or a misalignment flag through a single-cycle response pulse.

## Interface
- DATA_WIDTH, 32, data width of the memory word and the pipeline data
- ADDR_SIZE, 32, width of the byte address and the memory word index

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted on `req_valid && req_ready` at posedge
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved
- req_unsigned  in  1  loads only: zero-extend when set, sign-extend otherwise
- req_addr  in  ADDR_SIZE  byte address
- req_wdata  in  DATA_WIDTH  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_misaligned  out  1  qualified by resp_valid; alignment or size error
- mem_read  out  1  drives MemRead
- mem_write  out  1  drives MemWrite
- mem_addr  out  ADDR_SIZE  word index, `{2'b00, addr[ADDR_SIZE-1:2]}`
- mem_wr_data  out  DATA_WIDTH  drives wr_data
- mem_rd_data  in  DATA_WIDTH  from rd_data, combinational in the same cycle as mem_read

## Operation
- FSM states are IDLE, READ, WRITE and RESP.
- Request fields are latched on accept. req_ready is 1 only in IDLE.
- Alignment check happens at accept:
  - halfword needs addr[0]=0
  - word needs addr[1:0]=00
  - size 11 is always an error
  - On error the FSM goes IDLE→RESP with resp_misaligned=1 and issues no memory access.
- Load: IDLE→READ→RESP→IDLE.
  - In READ, mem_read=1 and mem_rd_data is registered at the end of the cycle.
- Word store: IDLE→WRITE→RESP→IDLE.
  - In WRITE, mem_write=1 and mem_wr_data=req_wdata.
- Sub-word store: IDLE→READ→WRITE→RESP→IDLE.
  - READ captures the old word.
  - WRITE writes the merged word and changes only the addressed lanes.
- Lanes are little-endian: byte k = bits [8k+7:8k] with k = addr[1:0]; halfword uses lanes {2·addr[1]+1, 2·addr[1]}.
- Load extract: shift the selected lane(s) to bit 0, then sign- or zero-extend per req_unsigned. req_unsigned is ignored for word loads.
- There is no range check on mem_addr. Staying within memory depth is the caller's responsibility.
- mem_read and mem_write are never both 1. Both are 0 in IDLE and RESP.
- mem_addr and mem_wr_data hold their latched values outside access states.

## Timing
- Reset values:
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_misaligned=0
  - mem_read=0, mem_write=0, mem_addr=0, mem_wr_data=0
- Latency from the accept edge to resp_valid high:
  - load or word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- resp_valid lasts exactly 1 cycle. There is no backpressure, so the consumer must sample it.
- Throughput is one request per (latency+1) cycles, because IDLE is re-entered before the next accept.
- A request held valid across a busy period is accepted only in IDLE, and exactly once per accept edge.
- resp_rdata and resp_misaligned are registered and stable only while resp_valid=1. They return to 0 afterwards.
- Reset mid-operation: the FSM goes to IDLE asynchronously and mem_write drops immediately. No partial RMW write is issued and no response is given for the aborted request.

## Structure
- Package mips_mem_pkg holds:
  - size encodings SIZE_B, SIZE_H, SIZE_W, SIZE_RSV
  - the state enum
  - the lane-select width constant
- One sub-module, lsu_byte_lane, is combinational. It does store-merge (old word, data, size, offset → new word) and load-extract (word, size, offset, unsigned → result).
- The FSM and registers live in mem_access_unit.

## Test plan
Data memory reset contents are word i = i.
- lw addr 0x0C → mem_addr=3, resp_rdata=0x00000003, resp_valid 2 cycles after accept.
- sb 0x80 @0x05, then lw @0x04 → 0x00008001; lb @0x05 → 0xFFFFFF80; lbu @0x05 → 0x00000080. Check the sb takes READ+WRITE, 3 cycles.
- sh 0xBEEF @0x0A, then lw @0x08 → 0xBEEF0002; lh @0x0A → 0xFFFFBEEF; lhu → 0x0000BEEF.
- lw @0x06, sh @0x03 and size 11 → resp_misaligned=1, resp_rdata=0, mem_read/mem_write never asserted, memory unchanged.
- Assert rst during the WRITE state of sb 0xFF @0x01 → mem_write deasserts immediately, no resp_valid, and word 0 reads back as its reset value 0.
- Hold req_valid high with two stores back-to-back → second is accepted only after RESP, exactly one mem_write per word store.
